// File: rtl/uart_pkg.sv
// Shared definitions for the byte-wide UART transmitter: FSM state encoding
// and frame geometry constants.
package uart_pkg;

    // Transmitter FSM states (2-bit encoding)
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    // Payload bits per frame, and full frame length (start + data + stop)
    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

endpackage : uart_pkg

// File: rtl/uart_byte_tx_if.sv
// Send/handshake bundle between the byte-sequencing controller (master)
// and the UART transmitter (slave).
interface uart_byte_tx_if;
    import uart_pkg::*;

    logic                 uart_tx_send;
    logic [DATA_BITS-1:0] uart_tx_data;
    logic                 uart_tx_done;
    logic                 uart_tx_busy;

    modport master (
        output uart_tx_send,
        output uart_tx_data,
        input  uart_tx_done,
        input  uart_tx_busy
    );

    modport slave (
        input  uart_tx_send,
        input  uart_tx_data,
        output uart_tx_done,
        output uart_tx_busy
    );

endinterface : uart_byte_tx_if

// File: rtl/uart_baud_tick.sv
// Bit-period counter: while enabled it counts 0..CLKS_PER_BIT-1 and flags the
// last cycle of every bit period. A clear restarts the period at count 0 so a
// new frame always begins on a clean bit boundary.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    // Tick marks the final cycle of the current bit period
    assign tick_o = en_i && (cnt_q == CNT_LAST);

    // Baud counter: cleared on frame start, wraps at each bit boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if (clear_i) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if (tick_o) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if (en_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

endmodule : uart_baud_tick

// File: rtl/uart_byte_tx.sv
// 8N1 UART transmitter. Accepts one byte per send request while idle and
// shifts it out LSB first between a low start bit and a high stop bit. Busy
// covers the whole frame; done pulses for one cycle as the line returns idle,
// so a send issued in that cycle starts the next frame with no idle gap.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic           clk,
    input  logic           rst,
    uart_byte_tx_if.slave  tx_if,
    output logic           uart_txd
);

    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    tx_state_e            state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [2:0]           bit_idx_q;
    logic                 txd_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 accept_s;
    logic                 baud_en_s;
    logic                 tick_s;
    logic [2:0]           next_idx_s;

    // A request is only taken while idle; requests during a frame are dropped
    assign accept_s   = (state_q == IDLE) && tx_if.uart_tx_send;
    assign baud_en_s  = (state_q != IDLE);
    assign next_idx_s = bit_idx_q + 3'd1;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk     (clk),
        .rst     (rst),
        .clear_i (accept_s),
        .en_i    (baud_en_s),
        .tick_o  (tick_s)
    );

    // Frame FSM with registered line, busy and done outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= {DATA_BITS{1'b0}};
            bit_idx_q <= 3'd0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        shift_q   <= tx_if.uart_tx_data;
                        bit_idx_q <= 3'd0;
                        state_q   <= START;
                        txd_q     <= 1'b0;
                        busy_q    <= 1'b1;
                    end else begin
                        txd_q  <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                START: begin
                    if (tick_s) begin
                        state_q   <= DATA;
                        bit_idx_q <= 3'd0;
                        txd_q     <= shift_q[0];
                    end else begin
                        txd_q <= 1'b0;
                    end
                end
                DATA: begin
                    if (tick_s) begin
                        if (bit_idx_q == LAST_IDX) begin
                            state_q <= STOP;
                            txd_q   <= 1'b1;
                        end else begin
                            bit_idx_q <= next_idx_s;
                            txd_q     <= shift_q[next_idx_s];
                        end
                    end else begin
                        txd_q <= shift_q[bit_idx_q];
                    end
                end
                STOP: begin
                    if (tick_s) begin
                        state_q   <= IDLE;
                        bit_idx_q <= 3'd0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end
                    txd_q <= 1'b1;
                end
                default: begin
                    state_q   <= IDLE;
                    bit_idx_q <= 3'd0;
                    txd_q     <= 1'b1;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign uart_txd           = txd_q;
    assign tx_if.uart_tx_busy = busy_q;
    assign tx_if.uart_tx_done = done_q;

endmodule : uart_byte_tx

// File: tb/tb_uart_byte_tx.sv
// Self-checking bench for uart_byte_tx. A frame-level reference model
// (cycles elapsed since acceptance -> line level) predicts txd/busy/done on
// every cycle; a mid-bit sampler recovers transmitted frames for byte checks.
module tb_uart_byte_tx;
    import uart_pkg::*;

    localparam int N     = 87;
    localparam int FRAME = FRAME_BITS * N;

    logic clk = 1'b0;
    logic rst;
    logic txd;

    uart_byte_tx_if u_if();

    uart_byte_tx #(.CLKS_PER_BIT(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_if    (u_if),
        .uart_txd (txd)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: m_k = cycles since the accept edge (0 = idle, no frame)
    int         m_k     = 0;
    logic [9:0] m_frame = 10'h3FF;

    always @(posedge clk) begin
        if (rst === 1'b1) m_k = 0;
        else if (m_k >= 1 && m_k <= FRAME) m_k = m_k + 1;
        else if (u_if.uart_tx_send === 1'b1) begin
            m_k     = 1;
            m_frame = {1'b1, u_if.uart_tx_data, 1'b0};
        end else m_k = 0;
    end

    // Expected {txd, busy, done} for the current cycle
    function automatic logic [2:0] exp_out();
        if (m_k >= 1 && m_k <= FRAME) return {m_frame[(m_k - 1) / N], 1'b1, 1'b0};
        else if (m_k == FRAME + 1)    return 3'b101;
        else                          return 3'b100;
    endfunction

    // Observation: done/busy counters and mid-bit line sampling
    int         done_seen = 0;
    int         busy_seen = 0;
    logic [9:0] rx_bits   = 10'h0;
    logic [9:0] rx_q[$];

    always @(negedge clk) begin
        if (u_if.uart_tx_done === 1'b1) done_seen++;
        if (u_if.uart_tx_busy === 1'b1) busy_seen++;
        if (m_k >= 1 && m_k <= FRAME && ((m_k - 1) % N) == N / 2)
            rx_bits[(m_k - 1) / N] = txd;
        if (m_k == FRAME) rx_q.push_back(rx_bits);
    end

    logic [2:0] obs;
    logic [2:0] exp_v;

    task automatic test_reset();
        rst = 1'b1;
        u_if.uart_tx_send = 1'b0;
        u_if.uart_tx_data = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            obs = {txd, u_if.uart_tx_busy, u_if.uart_tx_done};
            checks++;
            if (obs !== 3'b100) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: got %b want 100", i, obs);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            obs = {txd, u_if.uart_tx_busy, u_if.uart_tx_done};
            checks++;
            if (obs !== 3'b100) begin
                errors++;
                $display("FAIL reset_release cyc%0d: got %b want 100", i, obs);
            end
        end
    endtask

    task automatic test_single();
        int d0 = done_seen;
        int b0 = busy_seen;
        int r0 = rx_q.size();
        u_if.uart_tx_data = 8'h42;
        u_if.uart_tx_send = 1'b1;
        for (int j = 1; j <= 880; j++) begin
            @(negedge clk);
            obs = {txd, u_if.uart_tx_busy, u_if.uart_tx_done}; exp_v = exp_out();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL single j=%0d: got %b want %b", j, obs, exp_v);
            end
            if (j == 871) begin
                checks++;
                if (u_if.uart_tx_done !== 1'b1) begin
                    errors++;
                    $display("FAIL single_done_at_871: got %b want 1", u_if.uart_tx_done);
                end
            end
            u_if.uart_tx_send = 1'b0;
        end
        #1;
        checks++;
        if (done_seen - d0 !== 1) begin
            errors++; $display("FAIL single_done_count: got %0d want 1", done_seen - d0);
        end
        checks++;
        if (busy_seen - b0 !== 870) begin
            errors++; $display("FAIL single_busy_len: got %0d want 870", busy_seen - b0);
        end
        checks++;
        if (rx_q.size() != r0 + 1 || rx_q[r0] !== 10'b1010000100) begin
            errors++;
            $display("FAIL single_line_bits: got %b want 1010000100 (frames %0d)",
                     (rx_q.size() > r0) ? rx_q[r0] : 10'h0, rx_q.size() - r0);
        end
    endtask

    task automatic test_send_while_busy();
        int d0 = done_seen;
        int r0 = rx_q.size();
        u_if.uart_tx_data = 8'h42;
        u_if.uart_tx_send = 1'b1;
        for (int j = 1; j <= 900; j++) begin
            @(negedge clk);
            obs = {txd, u_if.uart_tx_busy, u_if.uart_tx_done}; exp_v = exp_out();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL busy_ignore j=%0d: got %b want %b", j, obs, exp_v);
            end
            if (j >= 100 && j < 110) begin
                u_if.uart_tx_send = 1'b1;
                u_if.uart_tx_data = 8'h61;
            end else begin
                u_if.uart_tx_send = 1'b0;
            end
        end
        #1;
        checks++;
        if (done_seen - d0 !== 1) begin
            errors++; $display("FAIL busy_ignore_done_count: got %0d want 1", done_seen - d0);
        end
        checks++;
        if (rx_q.size() != r0 + 1 || rx_q[r0] !== {1'b1, 8'h42, 1'b0}) begin
            errors++;
            $display("FAIL busy_ignore_byte: got %0d frames, want 1 frame of 0x42", rx_q.size() - r0);
        end
    endtask

    task automatic test_back_to_back();
        int  d0 = done_seen;
        int  r0 = rx_q.size();
        bit  second = 1'b0;
        int  after = -1;
        u_if.uart_tx_data = 8'h70;
        u_if.uart_tx_send = 1'b1;
        for (int j = 1; j <= 2000; j++) begin
            @(negedge clk);
            obs = {txd, u_if.uart_tx_busy, u_if.uart_tx_done}; exp_v = exp_out();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL b2b j=%0d: got %b want %b", j, obs, exp_v);
            end
            if (after == 0) begin
                checks++;
                if ({txd, u_if.uart_tx_busy} !== 2'b01) begin
                    errors++;
                    $display("FAIL b2b_no_gap: got txd/busy %b%b want 01", txd, u_if.uart_tx_busy);
                end
            end
            after = (after >= 0) ? after + 1 : after;
            u_if.uart_tx_send = 1'b0;
            if (u_if.uart_tx_done === 1'b1) begin
                if (!second) begin
                    second = 1'b1;
                    u_if.uart_tx_data = 8'h74;
                    u_if.uart_tx_send = 1'b1;
                    after = -1;
                end else begin
                    break;
                end
            end
            if (second && after < 0 && u_if.uart_tx_send === 1'b1) after = 0;
        end
        #1;
        checks++;
        if (done_seen - d0 !== 2) begin
            errors++; $display("FAIL b2b_done_count: got %0d want 2", done_seen - d0);
        end
        checks++;
        if (rx_q.size() != r0 + 2 || rx_q[r0] !== {1'b1, 8'h70, 1'b0} ||
            rx_q[r0 + 1] !== {1'b1, 8'h74, 1'b0}) begin
            errors++;
            $display("FAIL b2b_bytes: got %0d frames, want 0x70 then 0x74", rx_q.size() - r0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int d0 = done_seen;
        int r0;
        u_if.uart_tx_data = 8'($urandom);
        u_if.uart_tx_send = 1'b1;
        for (int j = 1; j <= 4 * N + 20; j++) begin
            @(negedge clk);
            obs = {txd, u_if.uart_tx_busy, u_if.uart_tx_done}; exp_v = exp_out();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL midrst_pre j=%0d: got %b want %b", j, obs, exp_v);
            end
            u_if.uart_tx_send = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        obs = {txd, u_if.uart_tx_busy, u_if.uart_tx_done};
        checks++;
        if (obs !== 3'b100) begin
            errors++; $display("FAIL midrst_abort: got %b want 100", obs);
        end
        rst = 1'b0;
        for (int j = 1; j <= 900; j++) begin
            @(negedge clk);
            obs = {txd, u_if.uart_tx_busy, u_if.uart_tx_done}; exp_v = exp_out();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL midrst_quiet j=%0d: got %b want %b", j, obs, exp_v);
            end
        end
        #1;
        checks++;
        if (done_seen - d0 !== 0) begin
            errors++; $display("FAIL midrst_no_done: got %0d pulses want 0", done_seen - d0);
        end
        r0 = rx_q.size();
        u_if.uart_tx_data = 8'h0A;
        u_if.uart_tx_send = 1'b1;
        for (int j = 1; j <= 880; j++) begin
            @(negedge clk);
            obs = {txd, u_if.uart_tx_busy, u_if.uart_tx_done}; exp_v = exp_out();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL midrst_resend j=%0d: got %b want %b", j, obs, exp_v);
            end
            u_if.uart_tx_send = 1'b0;
        end
        #1;
        checks++;
        if (rx_q.size() != r0 + 1 || rx_q[r0] !== {1'b1, 8'h0A, 1'b0}) begin
            errors++;
            $display("FAIL midrst_resend_byte: got %0d frames, want 1 frame of 0x0A", rx_q.size() - r0);
        end
    endtask

    task automatic test_data_change();
        int r0 = rx_q.size();
        u_if.uart_tx_data = 8'hC3;
        u_if.uart_tx_send = 1'b1;
        for (int j = 1; j <= 880; j++) begin
            @(negedge clk);
            obs = {txd, u_if.uart_tx_busy, u_if.uart_tx_done}; exp_v = exp_out();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL data_change j=%0d: got %b want %b", j, obs, exp_v);
            end
            u_if.uart_tx_send = 1'b0;
            u_if.uart_tx_data = (j == 1) ? 8'h3C : 8'($urandom);
        end
        #1;
        checks++;
        if (rx_q.size() != r0 + 1 || rx_q[r0] !== {1'b1, 8'hC3, 1'b0}) begin
            errors++;
            $display("FAIL data_change_byte: got %0d frames, want 1 frame of 0xC3", rx_q.size() - r0);
        end
    endtask

    task automatic test_random_stream();
        int         d0 = done_seen;
        int         r0 = rx_q.size();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int         gap;
        bit         got_done;
        for (int f = 0; f < 12; f++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            u_if.uart_tx_data = b;
            u_if.uart_tx_send = 1'b1;
            got_done = 1'b0;
            for (int k = 0; k < 1000 && !got_done; k++) begin
                @(negedge clk);
                obs = {txd, u_if.uart_tx_busy, u_if.uart_tx_done}; exp_v = exp_out();
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL random f=%0d k=%0d: got %b want %b", f, k, obs, exp_v);
                end
                got_done = (u_if.uart_tx_done === 1'b1);
                if (m_k >= 1 && m_k < FRAME) begin
                    u_if.uart_tx_send = ($urandom_range(0, 7) == 0);
                    u_if.uart_tx_data = 8'($urandom);
                end else begin
                    u_if.uart_tx_send = 1'b0;
                end
            end
            if (!got_done) begin
                errors++;
                $display("FAIL random_timeout f=%0d: no done within 1000 cycles", f);
            end
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                obs = {txd, u_if.uart_tx_busy, u_if.uart_tx_done}; exp_v = exp_out();
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL random_gap f=%0d g=%0d: got %b want %b", f, g, obs, exp_v);
                end
            end
        end
        u_if.uart_tx_send = 1'b0;
        #1;
        checks++;
        if (done_seen - d0 !== 12) begin
            errors++; $display("FAIL random_done_count: got %0d want 12", done_seen - d0);
        end
        for (int f = 0; f < 12; f++) begin
            checks++;
            if (rx_q.size() <= r0 + f || rx_q[r0 + f] !== {1'b1, exp_q[f], 1'b0}) begin
                errors++;
                $display("FAIL random_byte f=%0d: got %b want %b", f,
                         (rx_q.size() > r0 + f) ? rx_q[r0 + f] : 10'h0, {1'b1, exp_q[f], 1'b0});
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        u_if.uart_tx_send = 1'b0;
        u_if.uart_tx_data = 8'h00;
        test_reset();
        test_single();
        test_send_while_busy();
        test_back_to_back();
        test_reset_mid_frame();
        test_data_change();
        test_random_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_uart_byte_tx
